// File: rtl/vgachargen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vgachargen_pkg
// Purpose : Shared types and constants for the VGA character generator and
//           its APB slave: region decode enum, APB slave FSM state type,
//           memory depths and bus widths.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package vgachargen_pkg;

  localparam int APB_ADDR_WIDTH    = 32;
  localparam int APB_DATA_WIDTH    = 32;

  localparam int CH_MAP_DEPTH      = 2400;  // 80 x 30 text cells
  localparam int CH_MAP_ADDR_WIDTH = 12;
  localparam int CH_T_RW_DEPTH     = 128;
  localparam int CH_T_ADDR_WIDTH   = 7;
  localparam int CH_T_DATA_WIDTH   = 128;   // one 8x16 glyph per entry

  // Address region selected by paddr[15:14]
  typedef enum logic [1:0] {
    CH_MAP  = 2'b00,
    COL_MAP = 2'b01,
    CH_T_RW = 2'b10,
    RSVD    = 2'b11
  } apb_region_e;

  // APB slave transfer sequencer
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WAIT   = 2'b10,
    ST_DONE   = 2'b11
  } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/vgachargen_word_merge.sv
`default_nettype none
// ============================================================================
// Module  : vgachargen_word_merge
// Purpose : Replaces the strobed bytes of one 32-bit word inside a 128-bit
//           glyph row, leaving every other byte as read from memory.
// Ports   : word_i     - 32-bit word to insert
//           word_sel_i - which of the four words is targeted (word w = bits
//                        [32w+31:32w])
//           strb_i     - byte enables within the targeted word
//           data_i     - original 128-bit row
//           data_o     - merged 128-bit row
// Revision: 1.0 - initial release
// ============================================================================
module vgachargen_word_merge (
  input  logic [31:0]  word_i,
  input  logic [1:0]   word_sel_i,
  input  logic [3:0]   strb_i,
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  generate
    for (genvar w = 0; w < 4; w++) begin : g_word
      for (genvar b = 0; b < 4; b++) begin : g_byte
        assign data_o[32*w + 8*b +: 8] =
          ((word_sel_i == 2'(w)) && strb_i[b]) ? word_i[8*b +: 8]
                                               : data_i[32*w + 8*b +: 8];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vgachargen_apb_slave.sv
`default_nettype none
// ============================================================================
// Module  : vgachargen_apb_slave
// Purpose : APB4 responder giving bus access to the character map, colour
//           map and RW glyph table (port A of their dual-port BRAMs).
//           Map entries are 8 bits in data[7:0]; each 128-bit glyph row is
//           exposed as four 32-bit words and written by read-modify-write.
// Config  : VGACHARGEN_APB_STRB_EN - when defined, pstrb_i gates glyph bytes
//           and map writes require pstrb_i[0]; otherwise pstrb_i is ignored.
// Ports   : clk_i, arstn_i                 - clock, async active-low reset
//           psel_i/penable_i/pwrite_i,
//           paddr_i/pwdata_i/pstrb_i       - APB request
//           prdata_o/pready_o/pslverr_o    - APB response
//           ch_map_*   - character map port A (12b addr, 8b data, 1-cycle rd)
//           col_map_*  - colour map port A (same shape)
//           ch_t_rw_*  - glyph table port A (7b addr, 128b data, 1-cycle rd)
// Revision: 1.0 - initial release
// ============================================================================
module vgachargen_apb_slave #(
  parameter int CH_MAP_DEPTH  = vgachargen_pkg::CH_MAP_DEPTH,
  parameter int CH_T_RW_DEPTH = vgachargen_pkg::CH_T_RW_DEPTH
) (
  input  logic         clk_i,
  input  logic         arstn_i,
  input  logic         psel_i,
  input  logic         penable_i,
  input  logic         pwrite_i,
  input  logic [31:0]  paddr_i,
  input  logic [31:0]  pwdata_i,
  input  logic [3:0]   pstrb_i,
  output logic [31:0]  prdata_o,
  output logic         pready_o,
  output logic         pslverr_o,
  output logic [11:0]  ch_map_addr_o,
  output logic [7:0]   ch_map_data_o,
  output logic         ch_map_wen_o,
  input  logic [7:0]   ch_map_data_i,
  output logic [11:0]  col_map_addr_o,
  output logic [7:0]   col_map_data_o,
  output logic         col_map_wen_o,
  input  logic [7:0]   col_map_data_i,
  output logic [6:0]   ch_t_rw_addr_o,
  output logic [127:0] ch_t_rw_data_o,
  output logic         ch_t_rw_wen_o,
  input  logic [127:0] ch_t_rw_data_i
);

  import vgachargen_pkg::*;

  apb_state_e  state_q, state_d;
  apb_region_e region_q;
  logic [11:0] idx_q;      // paddr[13:2]: map index, or {glyph, word} for glyphs
  logic [31:0] wdata_q;
  logic        write_q;
  logic        err_q;

  apb_region_e w_region;
  logic        w_err;
  logic        w_setup;
  logic        w_map_strb_ok;
  logic [3:0]  w_strb;
  logic [31:0] w_rdata;
  logic [127:0] w_merged;
  logic        w_unused;

`ifdef VGACHARGEN_APB_STRB_EN
  logic [3:0]  strb_q;
  assign w_strb        = strb_q;
  assign w_map_strb_ok = strb_q[0];
  assign w_unused      = ^{paddr_i[31:16], paddr_i[1:0]};
`else
  assign w_strb        = 4'hF;
  assign w_map_strb_ok = 1'b1;
  assign w_unused      = ^{paddr_i[31:16], paddr_i[1:0], pstrb_i};
`endif

  // --------------------------------------------------------------------------
  // Address decode, evaluated on the setup cycle only
  // --------------------------------------------------------------------------
  assign w_region = apb_region_e'(paddr_i[15:14]);
  assign w_setup  = (state_q == ST_IDLE) && psel_i && !penable_i;

  always_comb begin
    w_err = 1'b0;
    case (w_region)
      CH_MAP, COL_MAP: w_err = ({20'b0, paddr_i[13:2]} >= 32'(CH_MAP_DEPTH));
      CH_T_RW:         w_err = (paddr_i[13:11] != 3'b000) ||
                               ({25'b0, paddr_i[10:4]} >= 32'(CH_T_RW_DEPTH));
      default:         w_err = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture: memory addresses/data are held from these registers
  // until the next setup, so port A stays stable across wait states.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      region_q <= CH_MAP;
      idx_q    <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef VGACHARGEN_APB_STRB_EN
      strb_q   <= '0;
`endif
    end else if (w_setup) begin
      region_q <= w_region;
      idx_q    <= paddr_i[13:2];
      wdata_q  <= pwdata_i;
      write_q  <= pwrite_i;
      err_q    <= w_err;
`ifdef VGACHARGEN_APB_STRB_EN
      strb_q   <= pstrb_i;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read data: maps zero-extend, glyphs return the selected 32-bit word
  always_comb begin
    w_rdata = '0;
    case (region_q)
      CH_MAP:  w_rdata = {24'b0, ch_map_data_i};
      COL_MAP: w_rdata = {24'b0, col_map_data_i};
      CH_T_RW: w_rdata = ch_t_rw_data_i[{idx_q[1:0], 5'b0} +: 32];
      default: w_rdata = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM next state and response/strobe outputs. psel_i is not consulted
  // after setup: an aborted transfer still runs to completion.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pready_o      = 1'b0;
    pslverr_o     = 1'b0;
    prdata_o      = '0;
    ch_map_wen_o  = 1'b0;
    col_map_wen_o = 1'b0;
    ch_t_rw_wen_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_setup) begin
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (err_q) begin
          pready_o  = 1'b1;
          pslverr_o = 1'b1;
          state_d   = ST_IDLE;
        end else if (write_q && (region_q != CH_T_RW)) begin
          pready_o      = 1'b1;
          ch_map_wen_o  = w_map_strb_ok && (region_q == CH_MAP);
          col_map_wen_o = w_map_strb_ok && (region_q == COL_MAP);
          state_d       = ST_IDLE;
        end else begin
          // Reads wait one cycle for BRAM data; glyph writes need the old row
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (write_q) begin
          // Only glyph writes reach here with write_q set
          ch_t_rw_wen_o = 1'b1;
          state_d       = ST_DONE;
        end else begin
          pready_o = 1'b1;
          prdata_o = w_rdata;
          state_d  = ST_IDLE;
        end
      end

      ST_DONE: begin
        pready_o = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory port A
  // --------------------------------------------------------------------------
  vgachargen_word_merge u_word_merge (
    .word_i     (wdata_q),
    .word_sel_i (idx_q[1:0]),
    .strb_i     (w_strb),
    .data_i     (ch_t_rw_data_i),
    .data_o     (w_merged)
  );

  assign ch_map_addr_o  = idx_q;
  assign ch_map_data_o  = wdata_q[7:0];
  assign col_map_addr_o = idx_q;
  assign col_map_data_o = wdata_q[7:0];
  assign ch_t_rw_addr_o = idx_q[8:2];
  // Merged row only shown during its strobe so the bus is quiet otherwise
  assign ch_t_rw_data_o = ch_t_rw_wen_o ? w_merged : '0;

endmodule
`default_nettype wire
